// File: rtl/compressor27_if.sv
// Bundle of the 27 column inputs and 32 result bits of the 27x27 column compressor.
interface compressor27_if;
    logic [26:0] src0,  src1,  src2,  src3,  src4,  src5,  src6,  src7,  src8;
    logic [26:0] src9,  src10, src11, src12, src13, src14, src15, src16, src17;
    logic [26:0] src18, src19, src20, src21, src22, src23, src24, src25, src26;

    logic dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7;
    logic dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15;
    logic dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23;
    logic dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31;

    // Upstream side: drives the columns and observes the sum.
    modport master (
        output src0,  src1,  src2,  src3,  src4,  src5,  src6,  src7,  src8,
               src9,  src10, src11, src12, src13, src14, src15, src16, src17,
               src18, src19, src20, src21, src22, src23, src24, src25, src26,
        input  dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
               dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
               dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
               dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31
    );

    // Compressor side: consumes the columns and produces the sum.
    modport slave (
        input  src0,  src1,  src2,  src3,  src4,  src5,  src6,  src7,  src8,
               src9,  src10, src11, src12, src13, src14, src15, src16, src17,
               src18, src19, src20, src21, src22, src23, src24, src25, src26,
        output dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
               dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
               dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
               dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31
    );
endinterface

// File: rtl/compressor27.sv
// 27-column x 27-bit dot-array compressor: sum of popcount(column i) * 2^i,
// reduced through a carry-save (3:2) tree to two rows, then one 32-bit CPA,
// registered once. The exact sum never exceeds 0xD7FFFFE5, so every carry
// row shifted left within 32 bits loses nothing.
module compressor27 (
    input  logic           clk,
    input  logic           rst_n,
    compressor27_if.slave  bus
);

    logic [26:0] col [27];
    logic [31:0] lvl0 [27];
    logic [31:0] lvl1 [18];
    logic [31:0] lvl2 [12];
    logic [31:0] lvl3 [8];
    logic [31:0] lvl4 [6];
    logic [31:0] lvl5 [4];
    logic [31:0] lvl6 [3];
    logic [31:0] lvl7 [2];
    logic [31:0] sum_d;
    logic [31:0] sum_q;

    function automatic logic [4:0] popcount27(input logic [26:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int b = 0; b < 27; b++) begin
            c = c + {4'd0, v[b]};
        end
        return c;
    endfunction

    function automatic logic [31:0] csa_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] csa_carry(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    // Gather the column inputs into an indexable array.
    always_comb begin
        col[0]  = bus.src0;  col[1]  = bus.src1;  col[2]  = bus.src2;
        col[3]  = bus.src3;  col[4]  = bus.src4;  col[5]  = bus.src5;
        col[6]  = bus.src6;  col[7]  = bus.src7;  col[8]  = bus.src8;
        col[9]  = bus.src9;  col[10] = bus.src10; col[11] = bus.src11;
        col[12] = bus.src12; col[13] = bus.src13; col[14] = bus.src14;
        col[15] = bus.src15; col[16] = bus.src16; col[17] = bus.src17;
        col[18] = bus.src18; col[19] = bus.src19; col[20] = bus.src20;
        col[21] = bus.src21; col[22] = bus.src22; col[23] = bus.src23;
        col[24] = bus.src24; col[25] = bus.src25; col[26] = bus.src26;
    end

    // Column popcounts placed at their weight form 27 partial-product rows,
    // which the 3:2 levels squeeze 27->18->12->8->6->4->3->2 before the CPA.
    always_comb begin
        for (int i = 0; i < 27; i++) begin
            lvl0[i] = {27'd0, popcount27(col[i])} << i;
        end
        for (int g = 0; g < 9; g++) begin
            lvl1[2*g]   = csa_sum  (lvl0[3*g], lvl0[3*g+1], lvl0[3*g+2]);
            lvl1[2*g+1] = csa_carry(lvl0[3*g], lvl0[3*g+1], lvl0[3*g+2]);
        end
        for (int g = 0; g < 6; g++) begin
            lvl2[2*g]   = csa_sum  (lvl1[3*g], lvl1[3*g+1], lvl1[3*g+2]);
            lvl2[2*g+1] = csa_carry(lvl1[3*g], lvl1[3*g+1], lvl1[3*g+2]);
        end
        for (int g = 0; g < 4; g++) begin
            lvl3[2*g]   = csa_sum  (lvl2[3*g], lvl2[3*g+1], lvl2[3*g+2]);
            lvl3[2*g+1] = csa_carry(lvl2[3*g], lvl2[3*g+1], lvl2[3*g+2]);
        end
        for (int g = 0; g < 2; g++) begin
            lvl4[2*g]   = csa_sum  (lvl3[3*g], lvl3[3*g+1], lvl3[3*g+2]);
            lvl4[2*g+1] = csa_carry(lvl3[3*g], lvl3[3*g+1], lvl3[3*g+2]);
        end
        lvl4[4] = lvl3[6];
        lvl4[5] = lvl3[7];
        for (int g = 0; g < 2; g++) begin
            lvl5[2*g]   = csa_sum  (lvl4[3*g], lvl4[3*g+1], lvl4[3*g+2]);
            lvl5[2*g+1] = csa_carry(lvl4[3*g], lvl4[3*g+1], lvl4[3*g+2]);
        end
        lvl6[0] = csa_sum  (lvl5[0], lvl5[1], lvl5[2]);
        lvl6[1] = csa_carry(lvl5[0], lvl5[1], lvl5[2]);
        lvl6[2] = lvl5[3];
        lvl7[0] = csa_sum  (lvl6[0], lvl6[1], lvl6[2]);
        lvl7[1] = csa_carry(lvl6[0], lvl6[1], lvl6[2]);
        sum_d   = lvl7[0] + lvl7[1];
    end

    // Single output register; async reset clears any in-flight sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.dst0  = sum_q[0];  assign bus.dst1  = sum_q[1];
    assign bus.dst2  = sum_q[2];  assign bus.dst3  = sum_q[3];
    assign bus.dst4  = sum_q[4];  assign bus.dst5  = sum_q[5];
    assign bus.dst6  = sum_q[6];  assign bus.dst7  = sum_q[7];
    assign bus.dst8  = sum_q[8];  assign bus.dst9  = sum_q[9];
    assign bus.dst10 = sum_q[10]; assign bus.dst11 = sum_q[11];
    assign bus.dst12 = sum_q[12]; assign bus.dst13 = sum_q[13];
    assign bus.dst14 = sum_q[14]; assign bus.dst15 = sum_q[15];
    assign bus.dst16 = sum_q[16]; assign bus.dst17 = sum_q[17];
    assign bus.dst18 = sum_q[18]; assign bus.dst19 = sum_q[19];
    assign bus.dst20 = sum_q[20]; assign bus.dst21 = sum_q[21];
    assign bus.dst22 = sum_q[22]; assign bus.dst23 = sum_q[23];
    assign bus.dst24 = sum_q[24]; assign bus.dst25 = sum_q[25];
    assign bus.dst26 = sum_q[26]; assign bus.dst27 = sum_q[27];
    assign bus.dst28 = sum_q[28]; assign bus.dst29 = sum_q[29];
    assign bus.dst30 = sum_q[30]; assign bus.dst31 = sum_q[31];

endmodule

// File: tb/tb_compressor27.sv
// Bench for compressor27: directed vectors plus random vectors, scoreboarded
// against a weighted-popcount reference sum.
module tb_compressor27;

    logic        clk;
    logic        rst_n;
    logic [26:0] src_tb [27];
    logic [31:0] dst_v;
    logic [31:0] exp_q [$];
    int          checks;
    int          errors;

    compressor27_if bus ();

    compressor27 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.src0  = src_tb[0];  assign bus.src1  = src_tb[1];  assign bus.src2  = src_tb[2];
    assign bus.src3  = src_tb[3];  assign bus.src4  = src_tb[4];  assign bus.src5  = src_tb[5];
    assign bus.src6  = src_tb[6];  assign bus.src7  = src_tb[7];  assign bus.src8  = src_tb[8];
    assign bus.src9  = src_tb[9];  assign bus.src10 = src_tb[10]; assign bus.src11 = src_tb[11];
    assign bus.src12 = src_tb[12]; assign bus.src13 = src_tb[13]; assign bus.src14 = src_tb[14];
    assign bus.src15 = src_tb[15]; assign bus.src16 = src_tb[16]; assign bus.src17 = src_tb[17];
    assign bus.src18 = src_tb[18]; assign bus.src19 = src_tb[19]; assign bus.src20 = src_tb[20];
    assign bus.src21 = src_tb[21]; assign bus.src22 = src_tb[22]; assign bus.src23 = src_tb[23];
    assign bus.src24 = src_tb[24]; assign bus.src25 = src_tb[25]; assign bus.src26 = src_tb[26];

    assign dst_v = {bus.dst31, bus.dst30, bus.dst29, bus.dst28, bus.dst27, bus.dst26,
                    bus.dst25, bus.dst24, bus.dst23, bus.dst22, bus.dst21, bus.dst20,
                    bus.dst19, bus.dst18, bus.dst17, bus.dst16, bus.dst15, bus.dst14,
                    bus.dst13, bus.dst12, bus.dst11, bus.dst10, bus.dst9,  bus.dst8,
                    bus.dst7,  bus.dst6,  bus.dst5,  bus.dst4,  bus.dst3,  bus.dst2,
                    bus.dst1,  bus.dst0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each set bit in column i is worth 2^i.
    function automatic logic [31:0] ref_sum();
        longint s;
        s = 0;
        for (int i = 0; i < 27; i++) begin
            s += longint'($countones(src_tb[i])) * (longint'(1) << i);
        end
        return s[31:0];
    endfunction

    // Issue: every edge with reset released produces one expected result.
    always @(posedge clk) begin
        if (rst_n) exp_q.push_back(ref_sum());
    end

    // Monitor: compare the registered output just after each edge.
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst_n) begin
            checks++;
            if (dst_v !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold: dst=%08h expected=00000000", dst_v);
            end
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dst_v !== e) begin
                errors++;
                $display("FAIL scoreboard: dst=%08h expected=%08h", dst_v, e);
            end
        end
    end

    task automatic set_all(input logic [26:0] v);
        for (int i = 0; i < 27; i++) src_tb[i] = v;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_dst(input string name, input logic [31:0] exp);
        checks++;
        if (dst_v !== exp) begin
            errors++;
            $display("FAIL %s: dst=%08h expected=%08h", name, dst_v, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_all(27'h0);
        #2;
        check_dst("reset_initial", 32'h0);
        step();
        step();
        rst_n = 1'b1;

        set_all(27'h0);
        step();
        check_dst("all_zero", 32'h0);

        src_tb[0] = 27'h7FFFFFF;
        step();
        check_dst("col0_full", 32'h0000001B);

        set_all(27'h0);
        src_tb[5] = 27'h4000000;
        step();
        check_dst("col5_msb", 32'h00000020);
        src_tb[5] = 27'h0000001;
        step();
        check_dst("col5_lsb", 32'h00000020);

        set_all(27'h0);
        src_tb[26] = 27'h1;
        step();
        check_dst("col26_one", 32'h04000000);

        set_all(27'h7FFFFFF);
        step();
        check_dst("all_ones_max", 32'hD7FFFFE5);

        set_all(27'h0);
        step();
        check_dst("b2b_zero", 32'h0);
        src_tb[0] = 27'h7FFFFFF;
        step();
        check_dst("b2b_col0", 32'h0000001B);

        set_all(27'h7FFFFFF);
        step();
        check_dst("hold_max", 32'hD7FFFFE5);
        #2;
        rst_n = 1'b0;
        #1;
        check_dst("async_reset_immediate", 32'h0);
        step();
        check_dst("async_reset_hold", 32'h0);
        rst_n = 1'b1;
        step();
        check_dst("reset_release_max", 32'hD7FFFFE5);

        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 27; i++) begin
                case ($urandom_range(0, 7))
                    0:       src_tb[i] = 27'h0;
                    1:       src_tb[i] = 27'h7FFFFFF;
                    default: src_tb[i] = 27'($urandom());
                endcase
            end
            step();
        end
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
